// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage : instruction-fetch stage of the 5-stage pipeline.
//
// Holds the program counter, presents it to instruction memory, and loads the
// returned word into the IF/ID pipeline register. The next PC is either
// PC+4 or the (word-aligned) branch target when the MEM-stage branch decision
// pcsrc is asserted. Also keeps a saturating count of fetched instructions.
//
// Ports
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   pcsrc          in   branch taken; flushes IF/ID and redirects the PC
//   branch_target  in   branch target address from EX/MEM
//   stall          in   hazard-unit hold request
//   imem_addr      out  instruction-memory address (equals pc)
//   imem_data      in   instruction word for imem_addr, same cycle
//   pc             out  current program counter
//   if_id_instr    out  IF/ID instruction register
//   if_id_npc      out  IF/ID next-PC register (fetch PC + 4)
//   if_id_valid    out  IF/ID holds a real fetched instruction
//   fetch_count    out  saturating count of instructions loaded into IF/ID
// ---------------------------------------------------------------------------
module if_stage #(
    parameter int unsigned       WIDTH    = 32,
    parameter logic [WIDTH-1:0]  RESET_PC = 32'h0000_0000,
    parameter logic [WIDTH-1:0]  NOP      = 32'h0000_0000,
    parameter int unsigned       CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pcsrc,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             stall,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_data,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] if_id_instr,
    output logic [WIDTH-1:0] if_id_npc,
    output logic             if_id_valid,
    output logic [CNT_W-1:0] fetch_count
);

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_instr;
    logic [WIDTH-1:0] r_npc;
    logic             r_valid;
    logic [CNT_W-1:0] r_count;

    logic [WIDTH-1:0] w_pc_plus4;
    logic [WIDTH-1:0] w_target_aligned;
    logic             w_count_sat;

    // Modulo 2^WIDTH: the top word wraps silently to address zero.
    assign w_pc_plus4       = r_pc + WIDTH'(4);
    assign w_target_aligned = {branch_target[WIDTH-1:2], 2'b00};
    assign w_count_sat      = &r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= RESET_PC;
            r_instr <= NOP;
            r_npc   <= '0;
            r_valid <= 1'b0;
            r_count <= '0;
        end else if (pcsrc) begin
            // A taken branch squashes the wrong-path fetch even while stalled.
            r_pc    <= w_target_aligned;
            r_instr <= NOP;
            r_npc   <= '0;
            r_valid <= 1'b0;
        end else if (!stall) begin
            r_pc    <= w_pc_plus4;
            r_instr <= imem_data;
            r_npc   <= w_pc_plus4;
            r_valid <= 1'b1;
            if (!w_count_sat) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign if_id_instr = r_instr;
    assign if_id_npc   = r_npc;
    assign if_id_valid = r_valid;
    assign fetch_count = r_count;

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage : self-checking bench for if_stage.
// Directed vectors from a table, hand-written async-reset and saturation
// sequences, then randomized traffic compared against a behavioural model.
// The counter is instantiated narrow so saturation is reachable quickly.
// ---------------------------------------------------------------------------
module tb_if_stage;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 4;
    localparam logic [31:0] NOP   = 32'h0000_0000;
    localparam int          CMAX  = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             pcsrc;
    logic [WIDTH-1:0] branch_target;
    logic             stall;
    logic [WIDTH-1:0] imem_addr;
    logic [WIDTH-1:0] imem_data;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] if_id_instr;
    logic [WIDTH-1:0] if_id_npc;
    logic             if_id_valid;
    logic [CNT_W-1:0] fetch_count;

    int n_checks;
    int n_errors;

    // behavioural model state
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_npc;
    logic        m_valid;
    int          m_cnt;

    if_stage #(
        .WIDTH    (WIDTH),
        .RESET_PC (32'h0000_0000),
        .NOP      (NOP),
        .CNT_W    (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pcsrc         (pcsrc),
        .branch_target (branch_target),
        .stall         (stall),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .pc            (pc),
        .if_id_instr   (if_id_instr),
        .if_id_npc     (if_id_npc),
        .if_id_valid   (if_id_valid),
        .fetch_count   (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        p;
        logic        s;
        logic [31:0] tgt;
        logic [31:0] data;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_npc;
        logic        e_valid;
        int          e_cnt;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h0;
        m_instr = NOP;
        m_npc   = 32'h0;
        m_valid = 1'b0;
        m_cnt   = 0;
    endtask

    task automatic model_edge(input logic p, input logic s, input logic [31:0] t, input logic [31:0] d);
        if (p) begin
            m_pc    = t & 32'hFFFF_FFFC;
            m_instr = NOP;
            m_npc   = 32'h0;
            m_valid = 1'b0;
        end else if (!s) begin
            m_instr = d;
            m_npc   = m_pc + 32'd4;
            m_pc    = m_pc + 32'd4;
            m_valid = 1'b1;
            m_cnt   = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
        end
    endtask

    // Called just after an active edge. Glitches the controls briefly, settles
    // them, then takes one edge and samples 1 time unit after it.
    task automatic step(input logic p, input logic s, input logic [31:0] t, input logic [31:0] d);
        pcsrc = ~p;
        stall = ~s;
        #1;
        pcsrc         = p;
        stall         = s;
        branch_target = t;
        imem_data     = d;
        @(posedge clk);
        model_edge(p, s, t, d);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".pc"},    pc,          m_pc);
        chk({tag, ".addr"},  imem_addr,   m_pc);
        chk({tag, ".instr"}, if_id_instr, m_instr);
        chk({tag, ".npc"},   if_id_npc,   m_npc);
        chk({tag, ".valid"}, 32'(if_id_valid), 32'(m_valid));
        chk({tag, ".cnt"},   32'(fetch_count), 32'(m_cnt));
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst_n         = 1'b0;
        pcsrc         = 1'b0;
        stall         = 1'b0;
        branch_target = '0;
        imem_data     = '0;
        model_reset();

        //              p  s  tgt            data           pc             instr          npc            v  cnt
        vecs[0]  = '{1'b0,1'b0,32'h0,        32'h2001_0005, 32'h4,         32'h2001_0005, 32'h4,         1'b1, 1};
        vecs[1]  = '{1'b0,1'b0,32'h0,        32'h2002_000A, 32'h8,         32'h2002_000A, 32'h8,         1'b1, 2};
        vecs[2]  = '{1'b0,1'b1,32'h0,        32'hDEAD_BEEF, 32'h8,         32'h2002_000A, 32'h8,         1'b1, 2};
        vecs[3]  = '{1'b0,1'b1,32'h0,        32'hDEAD_BEEF, 32'h8,         32'h2002_000A, 32'h8,         1'b1, 2};
        vecs[4]  = '{1'b0,1'b1,32'h0,        32'hDEAD_BEEF, 32'h8,         32'h2002_000A, 32'h8,         1'b1, 2};
        vecs[5]  = '{1'b0,1'b0,32'h0,        32'h3000_0001, 32'hC,         32'h3000_0001, 32'hC,         1'b1, 3};
        vecs[6]  = '{1'b0,1'b0,32'h0,        32'h3000_0002, 32'h10,        32'h3000_0002, 32'h10,        1'b1, 4};
        vecs[7]  = '{1'b1,1'b0,32'h43,       32'h3000_0003, 32'h40,        NOP,           32'h0,         1'b0, 4};
        vecs[8]  = '{1'b1,1'b1,32'h100,      32'h3000_0004, 32'h100,       NOP,           32'h0,         1'b0, 4};
        vecs[9]  = '{1'b1,1'b0,32'hFFFF_FFFF,32'h3000_0005, 32'hFFFF_FFFC, NOP,           32'h0,         1'b0, 4};
        vecs[10] = '{1'b0,1'b0,32'h0,        32'h4000_0004, 32'h0,         32'h4000_0004, 32'h0,         1'b1, 5};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check_model("reset");
        rst_n = 1'b1;

        // directed table
        for (int i = 0; i < 11; i++) begin
            step(vecs[i].p, vecs[i].s, vecs[i].tgt, vecs[i].data);
            chk($sformatf("vec%0d.pc", i),    pc,          vecs[i].e_pc);
            chk($sformatf("vec%0d.addr", i),  imem_addr,   vecs[i].e_pc);
            chk($sformatf("vec%0d.instr", i), if_id_instr, vecs[i].e_instr);
            chk($sformatf("vec%0d.npc", i),   if_id_npc,   vecs[i].e_npc);
            chk($sformatf("vec%0d.valid", i), 32'(if_id_valid), 32'(vecs[i].e_valid));
            chk($sformatf("vec%0d.cnt", i),   32'(fetch_count), 32'(vecs[i].e_cnt));
        end

        // async reset mid-cycle during a stall at pc=0x40, with pcsrc also up
        step(1'b1, 1'b0, 32'h40, 32'h5000_0000);
        chk("pre_rst.pc", pc, 32'h40);
        step(1'b0, 1'b1, 32'h0, 32'h5000_0001);
        chk("pre_rst.stall_pc", pc, 32'h40);
        pcsrc         = 1'b1;
        branch_target = 32'h0000_0200;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_model("async_rst");
        @(posedge clk);
        #1;
        check_model("rst_hold");
        pcsrc = 1'b0;
        stall = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_edge(1'b0, 1'b0, 32'h0, imem_data);
        check_model("rst_release");

        // counter saturation
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 32'h0, $urandom);
        end
        chk("sat.cnt", 32'(fetch_count), 32'(CMAX));
        check_model("sat");

        // randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, $urandom, $urandom);
            check_model($sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage pipeline, directly upstream of the branch AND gate's consumer path.
- Holds the program counter and selects the next PC from PC+4 or the branch target, using the resolved branch decision (pcsrc) that the branch AND gate produces.
- Drives the instruction-memory address and captures the returned word into the IF/ID pipeline register.
- Supports stall and branch flush, and keeps a saturating count of fetched instructions for debug.

Parameters:
- WIDTH, 32, width of PC, addresses and instruction words
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP, 32'h0000_0000, instruction word inserted into IF/ID on flush or reset
- CNT_W, 16, width of fetch_count

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- pcsrc  input  1  branch taken (membranch AND zero from MEM stage)
- branch_target  input  WIDTH  branch target address from EX/MEM
- stall  input  1  hazard-unit hold request
- imem_addr  output  WIDTH  instruction-memory address
- imem_data  input  WIDTH  instruction word, valid in the same cycle as imem_addr (combinational read)
- pc  output  WIDTH  current program counter
- if_id_instr  output  WIDTH  IF/ID instruction register
- if_id_npc  output  WIDTH  IF/ID next-PC register (fetch PC + 4)
- if_id_valid  output  1  IF/ID holds a real fetched instruction
- fetch_count  output  CNT_W  number of instructions loaded into IF/ID

Behaviour:
- One clock; reset is asynchronous and active-low. While rst_n=0:
  - pc=RESET_PC
  - if_id_instr=NOP
  - if_id_npc=0
  - if_id_valid=0
  - fetch_count=0
- Deassertion of rst_n is sampled on the next rising clk edge.
- imem_addr = pc, combinational, with zero added latency. The instruction at pc appears in if_id_instr one clock edge later.
- At each rising edge, actions are taken in priority order:
  1. pcsrc=1 (flush; overrides stall):
     - pc <= {branch_target[WIDTH-1:2], 2'b00}
     - if_id_instr <= NOP, if_id_npc <= 0, if_id_valid <= 0
     - fetch_count unchanged
  2. pcsrc=0, stall=1 (hold): pc, if_id_instr, if_id_npc, if_id_valid and fetch_count all hold their values.
  3. pcsrc=0, stall=0 (advance):
     - pc <= pc+4
     - if_id_instr <= imem_data, if_id_npc <= pc+4, if_id_valid <= 1
     - fetch_count <= fetch_count+1
- Arithmetic:
  - pc+4 is modulo 2^WIDTH, so 32'hFFFF_FFFC advances to 32'h0000_0000 with no error flag.
  - fetch_count saturates at all-ones and never wraps.
- Alignment: the branch_target low 2 bits are forced to 0; pc is always word-aligned.
- Reset asserted mid-operation (during stall or in the same cycle as pcsrc) immediately forces all reset values; reset dominates everything.
- pcsrc and stall are sampled only at clock edges; glitches between edges have no effect.
- The block contains no other state; it does not look at imem_data contents.

Test Plan:
- Reset, then release with imem_data = 32'h2001_0005 for cycle 0 and 32'h2002_000A for cycle 1:
  - After edge 1: pc=4, if_id_instr=32'h2001_0005, if_id_npc=4, if_id_valid=1, fetch_count=1.
  - After edge 2: pc=8, if_id_instr=32'h2002_000A, fetch_count=2.
- stall=1 for 3 cycles at pc=8: pc stays 8, IF/ID and fetch_count unchanged. After stall drops, pc=12 at the next edge.
- pcsrc=1, branch_target=32'h0000_0043 at pc=16: pc=32'h0000_0040, if_id_instr=NOP, if_id_valid=0, fetch_count unchanged.
- pcsrc=1 and stall=1 in the same cycle, branch_target=32'h100: the flush wins, pc=32'h100, if_id_valid=0.
- Wrap-around: branch to 32'hFFFF_FFFC, then advance once: pc=32'h0000_0000, if_id_npc=32'h0000_0000.
- Assert rst_n=0 asynchronously mid-cycle during a stall with pc=32'h40: pc=0, if_id_instr=NOP, if_id_valid=0 and fetch_count=0 immediately, without waiting for a clock edge.
